// File: rtl/test_seq_pkg.sv
// Shared state encoding, default parameter values and index-width helper for test_sequencer.
package test_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_RECORD = 3'd3,
      ST_FINISH = 3'd4
   } seq_state_e;

   localparam int unsigned DEF_NUM_TESTS      = 32'd8;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd1024;
   localparam int unsigned DEF_CNT_W          = 32'd8;

   // Width of a channel index; a single-channel build still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/test_seq_timer.sv
// WAIT-state watchdog: counts enabled cycles since the last clear and flags the
// final cycle of the allowed window. Only instantiated with TEST_SEQUENCER_TIMEOUT_EN.
module test_seq_timer #(
   parameter int unsigned LIMIT = 32'd16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned      CW   = $clog2(LIMIT);
   localparam logic [CW-1:0]    LAST = CW'(LIMIT - 32'd1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, then count up and park on the last window cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/test_sequencer.sv
// Runs NUM_TESTS test channels one after another and tallies their verdicts.
// Define TEST_SEQUENCER_TIMEOUT_EN to add a WAIT watchdog that fails silent channels.
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter  int unsigned NUM_TESTS      = DEF_NUM_TESTS,
   parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter  int unsigned CNT_W          = DEF_CNT_W,
   localparam int unsigned IDX_W          = idx_width(NUM_TESTS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   output logic [NUM_TESTS-1:0] test_start,
   input  logic [NUM_TESTS-1:0] test_done,
   input  logic [NUM_TESTS-1:0] test_pass,
   output logic                 busy,
   output logic                 campaign_done,
   output logic [IDX_W-1:0]     cur_test,
   output logic [CNT_W-1:0]     pass_count,
   output logic [CNT_W-1:0]     fail_count,
   output logic [NUM_TESTS-1:0] fail_mask,
   output logic [NUM_TESTS-1:0] timeout_mask
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   if ((NUM_TESTS < 32'd1) || (NUM_TESTS > 32'd32) || (TIMEOUT_CYCLES < 32'd2) || (CNT_W < 32'd1))
   begin : g_bad_params
      $error("test_sequencer: parameter out of legal range");
   end

   seq_state_e           state_q,   state_d;
   logic [IDX_W-1:0]     cur_q,     cur_d;
   logic [CNT_W-1:0]     pass_q,    pass_d;
   logic [CNT_W-1:0]     fail_q,    fail_d;
   logic [NUM_TESTS-1:0] fmask_q,   fmask_d;
   logic [NUM_TESTS-1:0] tmask_q,   tmask_d;
   logic [NUM_TESTS-1:0] start_q,   start_d;
   logic                 verdict_q, verdict_d;
   logic                 tout_q,    tout_d;
   logic                 busy_q,    busy_d;
   logic                 cdone_q,   cdone_d;

   logic done_sel_s;
   logic pass_sel_s;
   logic expired_s;

   assign done_sel_s = test_done[cur_q];
   assign pass_sel_s = test_pass[cur_q];

`ifdef TEST_SEQUENCER_TIMEOUT_EN
   logic wd_clear_s;
   logic wd_en_s;

   assign wd_clear_s = (state_q == ST_LAUNCH);
   assign wd_en_s    = (state_q == ST_WAIT);

   test_seq_timer #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (wd_clear_s),
      .enable  (wd_en_s),
      .expired (expired_s)
   );
`else
   assign expired_s = 1'b0;
`endif

   // Next state, result updates, and output values decoded from the next state.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      fmask_d   = fmask_q;
      tmask_d   = tmask_q;
      verdict_d = verdict_q;
      tout_d    = tout_q;
      start_d   = '0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_LAUNCH;
               cur_d   = '0;
               pass_d  = '0;
               fail_d  = '0;
               fmask_d = '0;
               tmask_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done arriving on the expiry cycle still counts as a real response.
            if (done_sel_s) begin
               state_d   = ST_RECORD;
               verdict_d = pass_sel_s;
               tout_d    = 1'b0;
            end else if (expired_s) begin
               state_d   = ST_RECORD;
               verdict_d = 1'b0;
               tout_d    = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RECORD: begin
            if (verdict_q) begin
               if (pass_q != CNT_MAX) begin
                  pass_d = pass_q + CNT_W'(1);
               end else begin
                  pass_d = pass_q;
               end
            end else begin
               if (fail_q != CNT_MAX) begin
                  fail_d = fail_q + CNT_W'(1);
               end else begin
                  fail_d = fail_q;
               end
               fmask_d[cur_q] = 1'b1;
               if (tout_q) begin
                  tmask_d[cur_q] = 1'b1;
               end else begin
                  tmask_d = tmask_q;
               end
            end
            if (cur_q == LAST_IDX) begin
               state_d = ST_FINISH;
            end else begin
               cur_d   = cur_q + IDX_W'(1);
               state_d = ST_LAUNCH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d  = (state_d != ST_IDLE);
      cdone_d = (state_d == ST_FINISH);
      if (state_d == ST_LAUNCH) begin
         start_d[cur_d] = 1'b1;
      end else begin
         start_d = '0;
      end
   end

   // State, results and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         fmask_q   <= '0;
         tmask_q   <= '0;
         start_q   <= '0;
         verdict_q <= 1'b0;
         tout_q    <= 1'b0;
         busy_q    <= 1'b0;
         cdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         fmask_q   <= fmask_d;
         tmask_q   <= tmask_d;
         start_q   <= start_d;
         verdict_q <= verdict_d;
         tout_q    <= tout_d;
         busy_q    <= busy_d;
         cdone_q   <= cdone_d;
      end
   end

   assign test_start    = start_q;
   assign busy          = busy_q;
   assign campaign_done = cdone_q;
   assign cur_test      = cur_q;
   assign pass_count    = pass_q;
   assign fail_count    = fail_q;
   assign fail_mask     = fmask_q;
   assign timeout_mask  = tmask_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized bench for test_sequencer: a campaign-timeline model predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_test_sequencer;

   localparam int NA  = 4;
   localparam int NB  = 5;
   localparam int TMO = 16;
`ifdef TEST_SEQUENCER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        sel_b = 1'b0;
   logic        run_v = 1'b0;
   logic [31:0] dn_v = '0;
   logic [31:0] ps_v = '0;

   logic          run_a, run_b;
   logic [NA-1:0] start_a, fmask_a, tmask_a;
   logic [NB-1:0] start_b, fmask_b, tmask_b;
   logic          busy_a, busy_b, cdone_a, cdone_b;
   logic [1:0]    cur_a;
   logic [2:0]    cur_b;
   logic [7:0]    pass_a, fail_a;
   logic [1:0]    pass_b, fail_b;

   assign run_a = run_v & ~sel_b;
   assign run_b = run_v & sel_b;

   test_sequencer #(.NUM_TESTS(NA), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut_a (
      .clk(clk), .reset_n(reset_n), .run(run_a), .test_start(start_a),
      .test_done(sel_b ? 4'b0000 : dn_v[NA-1:0]), .test_pass(ps_v[NA-1:0]),
      .busy(busy_a), .campaign_done(cdone_a), .cur_test(cur_a), .pass_count(pass_a),
      .fail_count(fail_a), .fail_mask(fmask_a), .timeout_mask(tmask_a));

   test_sequencer #(.NUM_TESTS(NB), .TIMEOUT_CYCLES(TMO), .CNT_W(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .run(run_b), .test_start(start_b),
      .test_done(sel_b ? dn_v[NB-1:0] : 5'b00000), .test_pass(ps_v[NB-1:0]),
      .busy(busy_b), .campaign_done(cdone_b), .cur_test(cur_b), .pass_count(pass_b),
      .fail_count(fail_b), .fail_mask(fmask_b), .timeout_mask(tmask_b));

   logic [31:0] o_start, o_cur, o_pass, o_fail, o_fmask, o_tmask;
   logic        o_busy, o_cdone;
   assign o_start = sel_b ? 32'(start_b) : 32'(start_a);
   assign o_cur   = sel_b ? 32'(cur_b)   : 32'(cur_a);
   assign o_pass  = sel_b ? 32'(pass_b)  : 32'(pass_a);
   assign o_fail  = sel_b ? 32'(fail_b)  : 32'(fail_a);
   assign o_fmask = sel_b ? 32'(fmask_b) : 32'(fmask_a);
   assign o_tmask = sel_b ? 32'(tmask_b) : 32'(tmask_a);
   assign o_busy  = sel_b ? busy_b  : busy_a;
   assign o_cdone = sel_b ? cdone_b : cdone_a;

   // Campaign plan and derived event timeline (cycle numbers count edges after run acceptance).
   int dly[8];
   bit vd[8];
   int lch[8], acc[8], rec[8];
   bit fl[8], to[8];
   int n_cur, cmax, fin;
   int cyc = 0;
   bit chk_en = 1'b0;
   bit force_spur = 1'b0;
   int cdone_at = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic plan();
      int t, w;
      t = 1;
      for (int i = 0; i < n_cur; i++) begin
         lch[i] = t;
         if (dly[i] >= 0 && (!TO_EN || dly[i] < TMO)) begin
            w = dly[i] + 1; acc[i] = t + 1 + dly[i]; fl[i] = !vd[i]; to[i] = 1'b0;
         end else begin
            w = TMO; acc[i] = -1; fl[i] = 1'b1; to[i] = 1'b1;
         end
         rec[i] = t + 1 + w;
         t = rec[i] + 1;
      end
      fin = t;
   endtask

   function automatic int exp_start(input int k);
      for (int i = 0; i < n_cur; i++) if (lch[i] == k) return 1 << i;
      return 0;
   endfunction

   function automatic int exp_cur(input int k);
      int c = 0;
      for (int i = 0; i < n_cur; i++) if (lch[i] <= k) c = i;
      return c;
   endfunction

   function automatic int exp_cnt(input int k, input bit want_fail);
      int c = 0;
      for (int i = 0; i < n_cur; i++) if (rec[i] < k && fl[i] == want_fail) c++;
      return (c > cmax) ? cmax : c;
   endfunction

   function automatic int exp_mask(input int k, input bit tmo_only);
      int m = 0;
      for (int i = 0; i < n_cur; i++)
         if (rec[i] < k && (tmo_only ? to[i] : fl[i])) m |= (1 << i);
      return m;
   endfunction

   // Per-cycle compare against the timeline model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("test_start",    o_start, exp_start(cyc));
         chk("busy",          o_busy,  (cyc >= 1 && cyc <= fin) ? 1 : 0);
         chk("campaign_done", o_cdone, (cyc == fin) ? 1 : 0);
         chk("cur_test",      o_cur,   exp_cur(cyc));
         chk("pass_count",    o_pass,  exp_cnt(cyc, 1'b0));
         chk("fail_count",    o_fail,  exp_cnt(cyc, 1'b1));
         chk("fail_mask",     o_fmask, exp_mask(cyc, 1'b0));
         chk("timeout_mask",  o_tmask, exp_mask(cyc, 1'b1));
         if (o_cdone) cdone_at = cyc;
      end
   end

   task automatic drive(input int k, input bit noise);
      dn_v = '0;
      ps_v = $urandom;
      for (int j = 0; j < n_cur; j++) begin
         if (k >= lch[j] + 1 && k < rec[j]) begin
            if (k == acc[j]) begin
               dn_v[j] = 1'b1;
               ps_v[j] = vd[j];
            end
         end else if (noise) begin
            dn_v[j] = ($urandom_range(0, 3) == 0);
         end
      end
      if (force_spur && k == lch[0])     dn_v[0] = 1'b1;
      if (force_spur && k == lch[0] + 1) dn_v[n_cur-1] = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_start"}, o_start, 0);
      chk({tag, "_busy"},  o_busy,  0);
      chk({tag, "_cdone"}, o_cdone, 0);
      chk({tag, "_cur"},   o_cur,   0);
      chk({tag, "_pass"},  o_pass,  0);
      chk({tag, "_fail"},  o_fail,  0);
      chk({tag, "_fmask"}, o_fmask, 0);
      chk({tag, "_tmask"}, o_tmask, 0);
   endtask

   task automatic campaign(input bit use_b, input bit noise, input int abort_k);
      sel_b = use_b;
      n_cur = use_b ? NB : NA;
      cmax  = use_b ? 3 : 255;
      plan();
      cdone_at = -1;
      @(posedge clk); #1;
      run_v = 1'b1;
      drive(0, noise);
      @(posedge clk);
      for (int k = 1; k <= fin + 2; k++) begin
         #1;
         if (k == abort_k) begin
            chk_en = 1'b0;
            run_v = 1'b0;
            reset_n = 1'b0;
            #1;
            check_all_zero("midrst");
            @(negedge clk);
            reset_n = 1'b1;
            for (int j = 0; j < 6; j++) begin
               @(posedge clk); #1;
               drive(0, 1'b1);
               #2;
               chk("post_rst_start", o_start, 0);
               chk("post_rst_busy",  o_busy,  0);
            end
            dn_v = '0;
            return;
         end
         run_v = noise && (k <= fin) && ($urandom_range(0, 3) == 0);
         drive(k, noise);
         cyc = k;
         chk_en = 1'b1;
         @(posedge clk);
      end
      chk_en = 1'b0;
      run_v = 1'b0;
      dn_v = '0;
      #2;
   endtask

   task automatic set_plan(input int d0, d1, d2, d3, d4, input bit v0, v1, v2, v3, v4);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3; dly[4] = d4;
      vd[0] = v0;  vd[1] = v1;  vd[2] = v2;  vd[3] = v3;  vd[4] = v4;
   endtask

   initial begin
      #12;
      check_all_zero("in_reset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #2;
         chk("idle_start", o_start, 0);
         chk("idle_busy",  o_busy,  0);
      end

      // All four pass on the first WAIT cycle.
      set_plan(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      campaign(1'b0, 1'b0, -1);
      chk("clean_pass", o_pass, 4);
      chk("clean_fail", o_fail, 0);
      chk("clean_fmask", o_fmask, 0);
      chk("clean_cdone_cycle", cdone_at, 13);

      // Channels 1 and 3 fail.
      set_plan(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
      campaign(1'b0, 1'b0, -1);
      chk("fail13_pass", o_pass, 2);
      chk("fail13_fail", o_fail, 2);
      chk("fail13_fmask", o_fmask, 10);

      // Spurious done on channel 3 during channel 0 WAIT, and done[0] during LAUNCH.
      force_spur = 1'b1;
      set_plan(3, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      campaign(1'b0, 1'b0, -1);
      force_spur = 1'b0;
      chk("spur_pass", o_pass, 4);
      chk("spur_fmask", o_fmask, 0);
      chk("spur_cdone_cycle", cdone_at, 16);

      if (TO_EN) begin
         set_plan(0, 0, -1, 0, 0, 1, 1, 1, 1, 1);
         campaign(1'b0, 1'b0, -1);
         chk("tmo_tmask", o_tmask, 4);
         chk("tmo_fmask", o_fmask, 4);
         chk("tmo_pass", o_pass, 3);
         chk("tmo_cdone_cycle", cdone_at, 28);
         set_plan(15, 0, 0, 0, 0, 1, 1, 1, 1, 1);
         campaign(1'b0, 1'b0, -1);
         chk("donewins_tmask", o_tmask, 0);
         chk("donewins_pass", o_pass, 4);
         set_plan(16, 0, 0, 0, 0, 1, 1, 1, 1, 1);
         campaign(1'b0, 1'b0, -1);
         chk("late_tmask", o_tmask, 1);
      end

      // Reset while channel 1 is in WAIT.
      set_plan(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      campaign(1'b0, 1'b0, 5);

      // Five channels, two-bit counters: pass count saturates.
      set_plan(0, 0, 0, 0, 0, 1, 1, 1, 1, 1);
      campaign(1'b1, 1'b0, -1);
      chk("sat_pass", o_pass, 3);
      chk("sat_fail", o_fail, 0);
      chk("sat_cdone_cycle", cdone_at, 16);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 5; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (!TO_EN)        dly[i] = $urandom_range(0, 5);
            else if (sel == 0) dly[i] = -1;
            else if (sel == 1) dly[i] = $urandom_range(14, 17);
            else               dly[i] = $urandom_range(0, 4);
            vd[i] = ($urandom_range(0, 2) != 0);
         end
         campaign(r[0], 1'b1, -1);
         chk("rand_cdone_cycle", cdone_at, fin);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
